// File: rtl/axi_arbiter_n.sv
// axi_arbiter_n: merges N cache-side AXI3 masters onto one outer AXI3 port.
// Reads and writes are arbitrated independently (round-robin or fixed
// priority). A read is held off while a write to the same cache line is in
// flight, so a refill never overtakes a pending write-back.
module axi_arbiter_n #(
  parameter int NUM_MASTERS      = 2,
  parameter int PRIORITY_MODE    = 0,
  parameter int LINE_OFFSET_BITS = 5,
  parameter int ID_W             = 4
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  // master-side read channels
  input  logic [32*NUM_MASTERS-1:0] m_araddr,
  input  logic [4*NUM_MASTERS-1:0]  m_arlen,
  input  logic [NUM_MASTERS-1:0]    m_arvalid,
  output logic [NUM_MASTERS-1:0]    m_arready,
  output logic [31:0]               m_rdata,
  output logic [NUM_MASTERS-1:0]    m_rlast,
  output logic [NUM_MASTERS-1:0]    m_rvalid,
  input  logic [NUM_MASTERS-1:0]    m_rready,
  // master-side write channels
  input  logic [32*NUM_MASTERS-1:0] m_awaddr,
  input  logic [4*NUM_MASTERS-1:0]  m_awlen,
  input  logic [3*NUM_MASTERS-1:0]  m_awsize,
  input  logic [NUM_MASTERS-1:0]    m_awvalid,
  output logic [NUM_MASTERS-1:0]    m_awready,
  input  logic [32*NUM_MASTERS-1:0] m_wdata,
  input  logic [4*NUM_MASTERS-1:0]  m_wstrb,
  input  logic [NUM_MASTERS-1:0]    m_wlast,
  input  logic [NUM_MASTERS-1:0]    m_wvalid,
  output logic [NUM_MASTERS-1:0]    m_wready,
  output logic [NUM_MASTERS-1:0]    m_bvalid,
  input  logic [NUM_MASTERS-1:0]    m_bready,
  // outer AR channel
  output logic [ID_W-1:0]           arid,
  output logic [31:0]               araddr,
  output logic [3:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  // outer R channel
  input  logic [ID_W-1:0]           rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  // outer AW channel
  output logic [ID_W-1:0]           awid,
  output logic [31:0]               awaddr,
  output logic [3:0]                awlen,
  output logic [2:0]                awsize,
  output logic [1:0]                awburst,
  output logic [1:0]                awlock,
  output logic [3:0]                awcache,
  output logic [2:0]                awprot,
  output logic                      awvalid,
  input  logic                      awready,
  // outer W channel
  output logic [ID_W-1:0]           wid,
  output logic [31:0]               wdata,
  output logic [3:0]                wstrb,
  output logic                      wlast,
  output logic                      wvalid,
  input  logic                      wready,
  // outer B channel
  input  logic [ID_W-1:0]           bid,
  input  logic [1:0]                bresp,
  input  logic                      bvalid,
  output logic                      bready
);

  localparam int IDX_W  = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int LINE_W = 32 - LINE_OFFSET_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  logic [31:0] araddr_a [NUM_MASTERS];
  logic [3:0]  arlen_a  [NUM_MASTERS];
  logic [31:0] awaddr_a [NUM_MASTERS];
  logic [3:0]  awlen_a  [NUM_MASTERS];
  logic [2:0]  awsize_a [NUM_MASTERS];
  logic [31:0] wdata_a  [NUM_MASTERS];
  logic [3:0]  wstrb_a  [NUM_MASTERS];

  logic [1:0]        r_state_q, r_state_d;
  logic [IDX_W-1:0]  r_grant_q, r_grant_d;
  logic [IDX_W-1:0]  r_ptr_q, r_ptr_d;
  logic [1:0]        w_state_q, w_state_d;
  logic [IDX_W-1:0]  w_grant_q, w_grant_d;
  logic [IDX_W-1:0]  w_ptr_q, w_ptr_d;
  logic [LINE_W-1:0] w_line_q, w_line_d;

  logic [NUM_MASTERS-1:0] rd_blocked;
  logic [NUM_MASTERS-1:0] r_cand;
  logic                   r_found, w_found;
  logic [IDX_W-1:0]       r_pick, w_pick;

  // The outer id/resp fields carry nothing this arbiter needs.
  logic unused_resp;
  assign unused_resp = ^{rid, rresp, bid, bresp};

  // Returns {found, index}: the first requester at or after ptr (round-robin)
  // or the lowest requesting index (fixed priority).
  function automatic logic [IDX_W:0] pick_master(input logic [NUM_MASTERS-1:0] req,
                                                 input logic [IDX_W-1:0] ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] j;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (PRIORITY_MODE != 0) begin
        j = IDX_W'(k);
      end else begin
        sum = {1'b0, ptr} + (IDX_W+1)'(k);
        if (sum >= (IDX_W+1)'(NUM_MASTERS)) sum = sum - (IDX_W+1)'(NUM_MASTERS);
        j = sum[IDX_W-1:0];
      end
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
    return (g == LAST_IDX) ? '0 : g + 1'b1;
  endfunction

  // Split the flat per-master buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      araddr_a[i] = m_araddr[i*32 +: 32];
      arlen_a[i]  = m_arlen[i*4 +: 4];
      awaddr_a[i] = m_awaddr[i*32 +: 32];
      awlen_a[i]  = m_awlen[i*4 +: 4];
      awsize_a[i] = m_awsize[i*3 +: 3];
      wdata_a[i]  = m_wdata[i*32 +: 32];
      wstrb_a[i]  = m_wstrb[i*4 +: 4];
    end
  end

  // Hold off any read whose line matches the write currently in flight.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      rd_blocked[i] = (w_state_q != W_IDLE) &&
                      (araddr_a[i][31:LINE_OFFSET_BITS] == w_line_q);
    end
    r_cand = m_arvalid & ~rd_blocked;
  end

  // Read FSM: grant in idle, forward AR, then forward R until the last beat.
  always_comb begin
    r_state_d = r_state_q;
    r_grant_d = r_grant_q;
    r_ptr_d   = r_ptr_q;
    {r_found, r_pick} = pick_master(r_cand, r_ptr_q);
    case (r_state_q)
      R_IDLE: if (r_found) begin
        r_grant_d = r_pick;
        r_state_d = R_ADDR;
      end
      R_ADDR: if (arready) r_state_d = R_DATA;
      R_DATA: if (rvalid && m_rready[r_grant_q] && rlast) begin
        r_state_d = R_IDLE;
        r_ptr_d   = next_ptr(r_grant_q);
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write FSM: grant and capture the line in idle, then AW, W beats, B.
  always_comb begin
    w_state_d = w_state_q;
    w_grant_d = w_grant_q;
    w_ptr_d   = w_ptr_q;
    w_line_d  = w_line_q;
    {w_found, w_pick} = pick_master(m_awvalid, w_ptr_q);
    case (w_state_q)
      W_IDLE: if (w_found) begin
        w_grant_d = w_pick;
        w_line_d  = awaddr_a[w_pick][31:LINE_OFFSET_BITS];
        w_state_d = W_ADDR;
      end
      W_ADDR: if (awready) w_state_d = W_DATA;
      W_DATA: if (m_wvalid[w_grant_q] && wready && m_wlast[w_grant_q]) w_state_d = W_RESP;
      W_RESP: if (bvalid && m_bready[w_grant_q]) begin
        w_state_d = W_IDLE;
        w_ptr_d   = next_ptr(w_grant_q);
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // State registers; reset drops both directions straight back to idle.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state_q <= R_IDLE;
      r_grant_q <= '0;
      r_ptr_q   <= '0;
      w_state_q <= W_IDLE;
      w_grant_q <= '0;
      w_ptr_q   <= '0;
      w_line_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_grant_q <= r_grant_d;
      r_ptr_q   <= r_ptr_d;
      w_state_q <= w_state_d;
      w_grant_q <= w_grant_d;
      w_ptr_q   <= w_ptr_d;
      w_line_q  <= w_line_d;
    end
  end

  // Read-side steering: only the granted master sees handshakes.
  always_comb begin
    arid      = ID_W'(r_grant_q);
    araddr    = araddr_a[r_grant_q];
    arlen     = arlen_a[r_grant_q];
    arsize    = 3'b010;
    arburst   = 2'b01;
    arlock    = 2'b00;
    arcache   = 4'b0000;
    arprot    = 3'b000;
    arvalid   = (r_state_q == R_ADDR);
    rready    = 1'b0;
    m_rdata   = rdata;
    m_arready = '0;
    m_rvalid  = '0;
    m_rlast   = '0;
    if (r_state_q == R_ADDR) m_arready[r_grant_q] = arready;
    if (r_state_q == R_DATA) begin
      m_rvalid[r_grant_q] = rvalid;
      m_rlast[r_grant_q]  = rvalid & rlast;
      rready              = m_rready[r_grant_q];
    end
  end

  // Write-side steering: only the granted master sees handshakes.
  always_comb begin
    awid      = ID_W'(w_grant_q);
    wid       = ID_W'(w_grant_q);
    awaddr    = awaddr_a[w_grant_q];
    awlen     = awlen_a[w_grant_q];
    awsize    = awsize_a[w_grant_q];
    awburst   = 2'b01;
    awlock    = 2'b00;
    awcache   = 4'b0000;
    awprot    = 3'b000;
    awvalid   = (w_state_q == W_ADDR);
    wdata     = wdata_a[w_grant_q];
    wstrb     = wstrb_a[w_grant_q];
    wlast     = (w_state_q == W_DATA) && m_wlast[w_grant_q];
    wvalid    = (w_state_q == W_DATA) && m_wvalid[w_grant_q];
    bready    = (w_state_q == W_RESP) && m_bready[w_grant_q];
    m_awready = '0;
    m_wready  = '0;
    m_bvalid  = '0;
    if (w_state_q == W_ADDR) m_awready[w_grant_q] = awready;
    if (w_state_q == W_DATA) m_wready[w_grant_q]  = wready;
    if (w_state_q == W_RESP) m_bvalid[w_grant_q]  = bvalid;
  end

endmodule

// File: doc/axi_arbiter_n.md
Name: axi_arbiter_n

Overview:
Parametrised N-master AXI3 arbiter that merges the I-cache, D-cache and future masters (uncached buffer, prefetcher) onto the single CPU AXI port in mycpu_top. Read and write paths are independent arbiters. Each supports round-robin or fixed-priority selection. Reads are blocked against an in-flight write to the same cache line (RAW hazard).

Parameters:
NUM_MASTERS, 2, number of master ports (2..8); master 0 = I-cache
PRIORITY_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
LINE_OFFSET_BITS, 5, low address bits ignored in read/write line comparison
ID_W, 4, width of outer id fields

Ports:
aclk  in  1  clock
aresetn  in  1  reset
m_araddr  in  32*N  per-master read address
m_arlen  in  4*N  per-master burst length-1
m_arvalid  in  N  read request
m_arready  out  N  read address accepted
m_rdata  out  32  read data, broadcast
m_rlast  out  N  last beat, granted master only
m_rvalid  out  N  read beat valid
m_rready  in  N  master accepts beat
m_awaddr  in  32*N  write address
m_awlen  in  4*N  write length-1
m_awsize  in  3*N  write size
m_awvalid  in  N  write request
m_awready  out  N  write address accepted
m_wdata  in  32*N  write data
m_wstrb  in  4*N  byte strobes
m_wlast  in  N  last write beat
m_wvalid  in  N  write beat valid
m_wready  out  N  write beat accepted
m_bvalid  out  N  write response
m_bready  in  N  master accepts response
arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid, arready  out/in  AXI3 AR channel
rid/rdata/rresp/rlast/rvalid, rready  in/out  AXI3 R channel
awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awvalid, awready  out/in  AXI3 AW channel
wid/wdata/wstrb/wlast/wvalid, wready  out/in  AXI3 W channel
bid/bresp/bvalid, bready  in/out  AXI3 B channel

Behaviour:
- One clock aclk; reset aresetn is asynchronous, active-low.
- On reset, both FSMs go to IDLE and rr pointers go to 0. All outer valids/readies and all m_* valids/readies are 0. rdata is don't-care.
- Constants:
  - arsize = 3'b010, arburst = awburst = 2'b01 (INCR).
  - lock, cache and prot = 0.
  - arid = awid = wid = granted index, zero-extended.
- Read FSM R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - In R_IDLE, candidates are m_arvalid masked by hazard.
  - If any candidate exists, latch grant g and go to R_ADDR on the next edge. Grant-to-arvalid latency is 1 cycle.
  - Round-robin selection takes the first candidate at or after rr_ptr, wrapping modulo N. Fixed priority takes the lowest index.
  - R_ADDR: arvalid = 1, araddr/arlen = master g's (combinational), m_arready[g] = arready. On arvalid & arready, go to R_DATA.
  - R_DATA: m_rvalid[g] = rvalid, m_rlast[g] = rlast & rvalid, rready = m_rready[g]. On rvalid & rready & rlast, go to R_IDLE and set rr_ptr = (g+1) mod N.
  - rid and rresp are ignored.
- Write FSM W_IDLE -> W_ADDR -> W_DATA -> W_RESP -> W_IDLE:
  - Grant rules are the same as for reads, using a separate rr pointer.
  - In W_IDLE, latch grant and awaddr.
  - W_ADDR: forwards awvalid/awready/awaddr/awlen/awsize.
  - W_DATA: forwards wdata/wstrb/wlast/wvalid/wready. Exits on wvalid & wready & wlast.
  - W_RESP: m_bvalid[g] = bvalid, bready = m_bready[g]. Exits on bvalid & bready, then the write rr pointer advances.
  - bid and bresp are ignored.
- Hazard: while the write FSM is not in W_IDLE, read candidate i is masked if m_araddr[i][31:LINE_OFFSET_BITS] equals the latched write line. The mask clears in the cycle after the B handshake.
- Read and write FSMs run concurrently and may both grant in the same cycle, to the same or different masters.
- A non-granted master sees all its readies/valids at 0. A master's request deasserting while it waits has no effect.
- Only one outstanding transaction per direction.
- Reset asserted mid-burst aborts immediately to IDLE. The outer interconnect is reset by the same aresetn.

Test Plan:
- N=2, RR: m_arvalid = 2'b11 from reset -> master 0 granted (araddr = m0 addr, arid = 0). After rlast, master 1 is granted. After its rlast, master 0 again.
- PRIORITY_MODE=1, N=3: m0 re-requests continuously and m2 is pending -> m0 is granted every time and m2 waits until m0 drops m_arvalid.
- Read burst arlen=7 with rvalid toggling each cycle -> exactly 8 beats reach m_rvalid[g] only, m_rlast on beat 8. Other masters' m_rvalid stays 0.
- D-cache write to 0x1FC0_0040 (awlen=7) in progress, I-cache read to 0x1FC0_0050 -> AR is held until the B handshake, then arvalid rises 1 cycle after W_IDLE. A read to 0x1FC0_0080 in parallel is granted immediately.
- Concurrent read (m0) and write (m1) issued in the same cycle -> arvalid and awvalid both assert 1 cycle later, arid=0, awid=wid=1.
- aresetn pulsed low mid read burst -> arvalid/rready/m_rvalid are 0 asynchronously. After release, the FSM is in idle and a new request is granted with 1-cycle latency.
